// File: rtl/select_encode_seq_pkg.sv
// Shared constants for the select/encode block: instruction field positions
// and the operand sequencer state encoding.
package select_encode_pkg;

  localparam int RA_HI  = 26;
  localparam int RA_LO  = 23;
  localparam int RB_HI  = 22;
  localparam int RB_LO  = 19;
  localparam int RC_HI  = 18;
  localparam int RC_LO  = 15;
  localparam int C1_MSB = 18;
  localparam int C2_MSB = 21;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD_B = 2'd1,
    S_RD_C = 2'd2,
    S_WR_A = 2'd3
  } seq_state_e;

endpackage

// File: rtl/select_encode_seq_decoder_onehot.sv
// 4-bit register index to one-hot enable; indices past NUM_REGS-1 give zero.
module decoder_onehot #(
  parameter int NUM_REGS = 16
) (
  input  logic [3:0]          idx,
  output logic [NUM_REGS-1:0] onehot
);

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_bit
    assign onehot[i] = (idx == 4'(i));
  end

endmodule

// File: rtl/select_encode_seq.sv
// Register select/encode with instruction register, constant sign extension,
// and a three-step automatic operand sequencer (read Rb, read Rc, write Ra).
module select_encode_seq
  import select_encode_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int DATA_W   = 32
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                ir_load,
  input  logic [DATA_W-1:0]   ir_in,
  output logic                ir_ready,
  input  logic                gra,
  input  logic                grb,
  input  logic                grc,
  input  logic                rin,
  input  logic                rout,
  input  logic                baout,
  input  logic                c_mode,
  input  logic                seq_start,
  output logic [NUM_REGS-1:0] reg_in,
  output logic [NUM_REGS-1:0] reg_out,
  output logic [DATA_W-1:0]   c_sign_extended,
  output logic                r0_ba_zero,
  output logic                gr_conflict,
  output logic                seq_busy,
  output logic                seq_done
);

  seq_state_e            state_q;
  logic [DATA_W-1:0]     ir_q, ir_nxt;
  logic [3:0]            ra, rb, rc, rb_nxt, idx;
  logic [NUM_REGS-1:0]   oh;
  logic                  man_sel, conflict, ba_r0;
  logic                  unused_ir_hi;

  assign seq_busy = (state_q != S_IDLE);
  assign ir_ready = !seq_busy;
  assign seq_done = (state_q == S_WR_A);

  // A load coinciding with seq_start must feed the first sequence step.
  assign ir_nxt = (ir_load && ir_ready) ? ir_in : ir_q;

  assign ra     = ir_q[RA_HI:RA_LO];
  assign rb     = ir_q[RB_HI:RB_LO];
  assign rc     = ir_q[RC_HI:RC_LO];
  assign rb_nxt = ir_nxt[RB_HI:RB_LO];
  assign unused_ir_hi = &{1'b0, ir_q[DATA_W-1:RA_HI+1]};

  assign c_sign_extended = c_mode
    ? {{(DATA_W-C2_MSB-1){ir_q[C2_MSB]}}, ir_q[C2_MSB:0]}
    : {{(DATA_W-C1_MSB-1){ir_q[C1_MSB]}}, ir_q[C1_MSB:0]};

  assign man_sel  = gra | grb | grc;
  assign conflict = (gra & grb) | (gra & grc) | (grb & grc);

  always_comb begin
    idx = '0;
    case (state_q)
      S_IDLE: begin
        if (seq_start)  idx = rb_nxt;
        else if (gra)   idx = ra;
        else if (grb)   idx = rb;
        else            idx = rc;
      end
      S_RD_B:  idx = rc;
      S_RD_C:  idx = ra;
      default: idx = '0;
    endcase
  end

  decoder_onehot #(.NUM_REGS(NUM_REGS)) u_dec (
    .idx    (idx),
    .onehot (oh)
  );

  // R0 used as a base address reads as zero on the bus rather than its contents.
  assign ba_r0 = man_sel && baout && !rout && (idx == 4'd0);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= S_IDLE;
      ir_q        <= '0;
      reg_in      <= '0;
      reg_out     <= '0;
      r0_ba_zero  <= 1'b0;
      gr_conflict <= 1'b0;
    end else begin
      ir_q <= ir_nxt;
      case (state_q)
        S_IDLE: begin
          if (seq_start) begin
            state_q     <= S_RD_B;
            reg_in      <= '0;
            reg_out     <= oh;
            r0_ba_zero  <= 1'b0;
            gr_conflict <= 1'b0;
          end else begin
            reg_in      <= (man_sel && rin) ? oh : '0;
            reg_out     <= (man_sel && (rout || baout) && !ba_r0) ? oh : '0;
            r0_ba_zero  <= ba_r0;
            gr_conflict <= conflict;
          end
        end
        S_RD_B: begin
          state_q <= S_RD_C;
          reg_in  <= '0;
          reg_out <= oh;
        end
        S_RD_C: begin
          state_q <= S_WR_A;
          reg_in  <= oh;
          reg_out <= '0;
        end
        default: begin
          state_q     <= S_IDLE;
          reg_in      <= '0;
          reg_out     <= '0;
          r0_ba_zero  <= 1'b0;
          gr_conflict <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_select_encode_seq.sv
// Directed bench: expected outputs queued per step, popped after each edge.
module tb_select_encode_seq;

  logic        clk = 1'b0;
  logic        clr;
  logic        ir_load, gra, grb, grc, rin, rout, baout, c_mode, seq_start;
  logic [31:0] ir_in;
  logic        ir_ready, r0_ba_zero, gr_conflict, seq_busy, seq_done;
  logic [15:0] reg_in, reg_out;
  logic [31:0] c_sign_extended;

  logic        u1_ir_load, u1_grc, u1_rout;
  logic [31:0] u1_ir_in;
  logic        u1_ir_ready, u1_r0, u1_conf, u1_busy, u1_done;
  logic [7:0]  u1_reg_in, u1_reg_out;
  logic [31:0] u1_csx;

  int pass_cnt = 0;
  int total    = 0;
  int step_no  = 0;

  typedef struct packed {
    logic [15:0] rin;
    logic [15:0] rout;
    logic        r0, conf, busy, done;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  select_encode_seq #(.NUM_REGS(16), .DATA_W(32)) u0 (
    .clk(clk), .clr(clr), .ir_load(ir_load), .ir_in(ir_in), .ir_ready(ir_ready),
    .gra(gra), .grb(grb), .grc(grc), .rin(rin), .rout(rout), .baout(baout),
    .c_mode(c_mode), .seq_start(seq_start), .reg_in(reg_in), .reg_out(reg_out),
    .c_sign_extended(c_sign_extended), .r0_ba_zero(r0_ba_zero),
    .gr_conflict(gr_conflict), .seq_busy(seq_busy), .seq_done(seq_done)
  );

  select_encode_seq #(.NUM_REGS(8), .DATA_W(32)) u1 (
    .clk(clk), .clr(clr), .ir_load(u1_ir_load), .ir_in(u1_ir_in), .ir_ready(u1_ir_ready),
    .gra(1'b0), .grb(1'b0), .grc(u1_grc), .rin(1'b0), .rout(u1_rout), .baout(1'b0),
    .c_mode(1'b0), .seq_start(1'b0), .reg_in(u1_reg_in), .reg_out(u1_reg_out),
    .c_sign_extended(u1_csx), .r0_ba_zero(u1_r0),
    .gr_conflict(u1_conf), .seq_busy(u1_busy), .seq_done(u1_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) pass_cnt++;
    else $error("FAIL %s step %0d: observed %h expected %h", tag, step_no, obs, expv);
  endtask

  function automatic exp_t mk(logic [15:0] ri, logic [15:0] ro, logic r0, logic cf,
                              logic bz, logic dn);
    exp_t e;
    e.rin = ri; e.rout = ro; e.r0 = r0; e.conf = cf; e.busy = bz; e.done = dn;
    return e;
  endfunction

  task automatic drv(input logic ld, input logic [31:0] ir, input logic [2:0] g,
                     input logic [2:0] s, input logic ss);
    ir_load = ld; ir_in = ir;
    {gra, grb, grc}     = g;
    {rin, rout, baout}  = s;
    seq_start = ss;
  endtask

  task automatic step(input exp_t e);
    exp_t got;
    sb.push_back(e);
    @(posedge clk);
    #1;
    step_no++;
    got = sb.pop_front();
    chk("reg_in",      32'(reg_in),      32'(got.rin));
    chk("reg_out",     32'(reg_out),     32'(got.rout));
    chk("r0_ba_zero",  32'(r0_ba_zero),  32'(got.r0));
    chk("gr_conflict", 32'(gr_conflict), 32'(got.conf));
    chk("seq_busy",    32'(seq_busy),    32'(got.busy));
    chk("seq_done",    32'(seq_done),    32'(got.done));
    chk("ir_ready",    32'(ir_ready),    32'(!got.busy));
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_reg_in"},  32'(reg_in),      32'h0);
    chk({tag, "_reg_out"}, 32'(reg_out),     32'h0);
    chk({tag, "_r0"},      32'(r0_ba_zero),  32'h0);
    chk({tag, "_conf"},    32'(gr_conflict), 32'h0);
    chk({tag, "_busy"},    32'(seq_busy),    32'h0);
    chk({tag, "_done"},    32'(seq_done),    32'h0);
    chk({tag, "_ready"},   32'(ir_ready),    32'h1);
    chk({tag, "_csx"},     c_sign_extended,  32'h0);
  endtask

  initial begin
    clr = 1'b1; c_mode = 1'b0;
    drv(1'b0, 32'h0, 3'b000, 3'b000, 1'b0);
    u1_ir_load = 1'b0; u1_ir_in = 32'h0; u1_grc = 1'b0; u1_rout = 1'b0;
    #2;
    chk_cleared("reset");
    @(negedge clk);
    clr = 1'b0;

    // constant sign extension
    drv(1'b1, 32'h029B8005, 3'b000, 3'b000, 1'b0);
    step(mk(16'h0, 16'h0, 0, 0, 0, 0));
    drv(1'b0, 32'h0, 3'b000, 3'b000, 1'b0);
    c_mode = 1'b0; #1 chk("csx_c1", c_sign_extended, 32'h00038005);
    c_mode = 1'b1; #1 chk("csx_c2", c_sign_extended, 32'h001B8005);
    c_mode = 1'b0;

    // full sequence; loads and manual strobes while busy must be ignored
    drv(1'b0, 32'h0, 3'b000, 3'b000, 1'b1);
    step(mk(16'h0, 16'h0008, 0, 0, 1, 0));
    drv(1'b1, 32'h0007FFFF, 3'b110, 3'b100, 1'b1);
    step(mk(16'h0, 16'h0080, 0, 0, 1, 0));
    step(mk(16'h0020, 16'h0, 0, 0, 1, 1));
    step(mk(16'h0, 16'h0, 0, 0, 0, 0));
    drv(1'b0, 32'h0, 3'b000, 3'b000, 1'b0);
    #1 chk("ir_held_busy", c_sign_extended, 32'h00038005);

    drv(1'b1, 32'h0007FFFF, 3'b000, 3'b000, 1'b0);
    step(mk(16'h0, 16'h0, 0, 0, 0, 0));
    chk("csx_neg", c_sign_extended, 32'hFFFFFFFF);

    // manual mode: R0 base address, plain read, conflict with gra priority
    drv(1'b1, 32'h02800000, 3'b000, 3'b000, 1'b0);
    step(mk(16'h0, 16'h0, 0, 0, 0, 0));
    drv(1'b0, 32'h0, 3'b010, 3'b001, 1'b0);
    step(mk(16'h0, 16'h0, 1, 0, 0, 0));
    drv(1'b0, 32'h0, 3'b010, 3'b010, 1'b0);
    step(mk(16'h0, 16'h0001, 0, 0, 0, 0));
    drv(1'b0, 32'h0, 3'b110, 3'b100, 1'b0);
    step(mk(16'h0020, 16'h0, 0, 1, 0, 0));

    // same-edge load and start uses new fields; then abort in RD_C
    drv(1'b1, 32'h029B8005, 3'b000, 3'b000, 1'b1);
    step(mk(16'h0, 16'h0008, 0, 0, 1, 0));
    drv(1'b0, 32'h0, 3'b000, 3'b000, 1'b0);
    step(mk(16'h0, 16'h0080, 0, 0, 1, 0));
    clr = 1'b1;
    #1 chk_cleared("abort");
    @(negedge clk);
    clr = 1'b0;
    step(mk(16'h0, 16'h0, 0, 0, 0, 0));
    drv(1'b1, 32'h029B8005, 3'b000, 3'b000, 1'b1);
    step(mk(16'h0, 16'h0008, 0, 0, 1, 0));
    drv(1'b0, 32'h0, 3'b000, 3'b000, 1'b0);
    step(mk(16'h0, 16'h0080, 0, 0, 1, 0));
    step(mk(16'h0020, 16'h0, 0, 0, 1, 1));
    step(mk(16'h0, 16'h0, 0, 0, 0, 0));

    // NUM_REGS=8: out-of-range Rc decodes to nothing, in-range still works
    u1_ir_load = 1'b1; u1_ir_in = 32'h00060000;
    step(mk(16'h0, 16'h0, 0, 0, 0, 0));
    u1_ir_load = 1'b0; u1_grc = 1'b1; u1_rout = 1'b1;
    step(mk(16'h0, 16'h0, 0, 0, 0, 0));
    chk("n8_rc12", 32'(u1_reg_out), 32'h0);
    u1_grc = 1'b0; u1_rout = 1'b0; u1_ir_load = 1'b1; u1_ir_in = 32'h00018000;
    step(mk(16'h0, 16'h0, 0, 0, 0, 0));
    u1_ir_load = 1'b0; u1_grc = 1'b1; u1_rout = 1'b1;
    step(mk(16'h0, 16'h0, 0, 0, 0, 0));
    chk("n8_rc3", 32'(u1_reg_out), 32'h08);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/select_encode_seq.md
SELECT_ENCODE_SEQ -- requirements
Module: select_encode_seq

Interface
REQ-001 Parameter NUM_REGS, default 16: number of general registers; legal 2..16.
REQ-002 Parameter DATA_W, default 32: instruction and constant width.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 clr  in  1  reset, asynchronous, active-high.
REQ-005 ir_load  in  1  capture ir_in into internal IR when ir_ready=1.
REQ-006 ir_in  in  DATA_W  instruction word.
REQ-007 ir_ready  out  1  high when IR may be loaded (= !seq_busy).
REQ-008 gra, grb, grc  in  1 each  manual field select (Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15]).
REQ-009 rin, rout, baout  in  1 each  manual register write / read / base-address read strobes.
REQ-010 c_mode  in  1  constant select: 0 = IR[18:0], 1 = IR[21:0].
REQ-011 seq_start  in  1  launch automatic operand sequence.
REQ-012 reg_in  out  NUM_REGS  one-hot register write enables.
REQ-013 reg_out  out  NUM_REGS  one-hot register read enables.
REQ-014 c_sign_extended  out  DATA_W  sign-extended constant.
REQ-015 r0_ba_zero  out  1  BAout of R0 requested; bus must drive zero.
REQ-016 gr_conflict  out  1  more than one of gra/grb/grc sampled high.
REQ-017 seq_busy, seq_done  out  1 each  sequencer active / final-step marker.

Function
REQ-018 IR SHALL load on the rising edge when ir_load=1 and ir_ready=1; ir_load SHALL be ignored while seq_busy=1.
REQ-019 c_sign_extended SHALL be combinational from the held IR: bit 18 (c_mode=0) or bit 21 (c_mode=1) replicated to DATA_W.
REQ-020 A field value >= NUM_REGS SHALL decode to all-zero one-hot.
REQ-021 Manual mode (sequencer IDLE): select priority gra > grb > grc; gr_conflict registered each edge from the sampled gr inputs.
REQ-022 Manual outputs SHALL be registered, 1-cycle latency: reg_in = onehot & rin; reg_out = onehot & (rout | baout).
REQ-023 When baout=1, rout=0 and the selected index is 0, reg_out SHALL be zero and r0_ba_zero SHALL be 1 for that cycle.
REQ-024 Sequencer states IDLE -> RD_B -> RD_C -> WR_A -> IDLE, one clock each; seq_start sampled only in IDLE.
REQ-025 Edge sampling seq_start: reg_out=onehot(Rb); next edge: reg_out=onehot(Rc); next: reg_in=onehot(Ra), reg_out=0, seq_done=1; next: IDLE, manual outputs resume.
REQ-026 seq_busy SHALL be 1 in RD_B, RD_C, WR_A; manual gr/rin/rout/baout and seq_start SHALL be ignored while busy; gr_conflict held 0.
REQ-027 ir_load and seq_start on the same edge in IDLE: IR loads and the sequence uses the newly loaded fields.
REQ-028 reg_in and reg_out SHALL never both be non-zero in the same cycle during a sequence.

Reset
REQ-029 clr=1 SHALL immediately force IR=0, state IDLE, and reg_in, reg_out, r0_ba_zero, gr_conflict, seq_busy, seq_done to 0; ir_ready=1.
REQ-030 clr mid-sequence SHALL abort without a seq_done pulse; first edge after release behaves as IDLE.

Structure
REQ-031 Package select_encode_pkg SHALL hold field bit-position constants (RA/RB/RC hi/lo, C1/C2 msb) and the sequencer state enum.
REQ-032 One sub-module decoder_onehot (parameter NUM_REGS, 4-bit index in, one-hot out, out-of-range -> 0) SHALL be instantiated for the decode.

Verification
REQ-033 Load 0x029B8005, c_mode 0/1 -> c_sign_extended 0x00038005 / 0x001B8005; load 0x0007FFFF, c_mode=0 -> 0xFFFFFFFF.
REQ-034 IR 0x029B8005, seq_start -> reg_out 0x0008, then 0x0080, then reg_in 0x0020 with seq_done=1, then idle; ir_ready low for 3 cycles.
REQ-035 IR 0x02800000, grb=1, baout=1 -> reg_out 0x0000, r0_ba_zero=1; grb=1, rout=1 -> reg_out 0x0001.
REQ-036 gra=grb=1, rin=1, IR Ra=5 -> reg_in 0x0020, gr_conflict=1.
REQ-037 NUM_REGS=8, IR Rc=12, grc=1, rout=1 -> reg_out 0x00.
REQ-038 clr asserted in RD_C -> all outputs 0 at once, no seq_done, next seq_start restarts at RD_B.
